// File: rtl/gpzda_field_parser.sv
// gpzda_field_parser
//
// Parses the time and date fields of an NMEA $GPZDA sentence and checks its
// XOR checksum. The upstream header comparer flags (header_resolve) the cycle
// in which the final 'A' of "$GPZDA" is loaded. From then on this block
// consumes the same byte stream. It ends with either a one-cycle valid pulse
// carrying fresh BCD time/date, or a one-cycle error pulse carrying a reason.
//
// Ports
//   clock          system clock
//   reset          synchronous, active-high; returns the block to IDLE
//   load           data holds a new received byte this cycle
//   data           received ASCII byte
//   header_resolve header comparer matched "$GPZDA" on this byte
//   hour/minute/second/day/month  two-digit BCD, updated only on valid
//   year           four-digit BCD, updated only on valid
//   valid          one-cycle pulse, sentence accepted
//   error          one-cycle pulse, sentence rejected
//   err_code       0 format, 1 checksum, 2 aborted by '$' (qualified by error)

module gpzda_field_parser #(
  parameter int MAX_SKIP = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  data,
  input  logic        header_resolve,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  second,
  output logic [7:0]  day,
  output logic [7:0]  month,
  output logic [15:0] year,
  output logic        valid,
  output logic        error,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    IDLE, COMMA0, TIME, FRAC, DAY, MONTH, YEAR, SKIP, CK_HI, CK_LO
  } state_t;

  localparam int SKIP_W = $clog2(MAX_SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_LIMIT = SKIP_W'(MAX_SKIP);

  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  // XOR of the characters "GPZDA", the part of the header inside checksum scope
  localparam logic [7:0] HDR_XOR   = 8'h48;

  state_t            state, state_next;
  logic [2:0]        digit_cnt, digit_cnt_next;
  logic [SKIP_W-1:0] skip_cnt, skip_cnt_next;
  logic [7:0]        csum, csum_next;
  logic [3:0]        ck_hi, ck_hi_next;
  logic [23:0]       time_sh, time_sh_next;
  logic [7:0]        day_sh, day_sh_next;
  logic [7:0]        month_sh, month_sh_next;
  logic [15:0]       year_sh, year_sh_next;
  logic              valid_next, error_next;
  logic [1:0]        code_next;
  logic              fmt_err;

  logic       is_digit, is_hex;
  logic [3:0] hex_val;

  // Only uppercase hex counts; 'A'..'F' have low nibbles 1..6, hence the +9
  assign is_digit = (data >= 8'h30) && (data <= 8'h39);
  assign is_hex   = is_digit || ((data >= 8'h41) && (data <= 8'h46));
  assign hex_val  = is_digit ? data[3:0] : data[3:0] + 4'd9;

  // Next-state logic. A header match restarts the parse ahead of anything else.
  // A '$' aborts any sentence in progress. Otherwise each field collects its
  // digits into a shift-register shadow and counts them in digit_cnt.
  always_comb begin
    state_next     = state;
    digit_cnt_next = digit_cnt;
    skip_cnt_next  = skip_cnt;
    csum_next      = csum;
    ck_hi_next     = ck_hi;
    time_sh_next   = time_sh;
    day_sh_next    = day_sh;
    month_sh_next  = month_sh;
    year_sh_next   = year_sh;
    valid_next     = 1'b0;
    error_next     = 1'b0;
    code_next      = err_code;
    fmt_err        = 1'b0;

    if (load) begin
      if (header_resolve) begin
        state_next     = COMMA0;
        csum_next      = HDR_XOR;
        digit_cnt_next = 3'd0;
      end else if (state != IDLE && data == CH_DOLLAR) begin
        state_next = IDLE;
        error_next = 1'b1;
        code_next  = 2'd2;
      end else begin
        // Every byte between the header and '*' is covered by the checksum
        if (state != IDLE && state != CK_HI && state != CK_LO &&
            !(state == SKIP && data == CH_STAR))
          csum_next = csum ^ data;

        case (state)
          COMMA0: begin
            if (data == CH_COMMA) begin
              state_next     = TIME;
              digit_cnt_next = 3'd0;
            end else fmt_err = 1'b1;
          end
          TIME: begin
            if (is_digit) begin
              if (digit_cnt == 3'd6) fmt_err = 1'b1;
              else begin
                time_sh_next   = {time_sh[19:0], data[3:0]};
                digit_cnt_next = digit_cnt + 3'd1;
              end
            end else if ((data == CH_DOT || data == CH_COMMA) && digit_cnt == 3'd6) begin
              state_next     = (data == CH_DOT) ? FRAC : DAY;
              digit_cnt_next = 3'd0;
            end else fmt_err = 1'b1;
          end
          FRAC: begin
            // Fractional seconds are checked for shape but not kept
            if (is_digit) begin
              if (digit_cnt == 3'd3) fmt_err = 1'b1;
              else digit_cnt_next = digit_cnt + 3'd1;
            end else if (data == CH_COMMA && digit_cnt != 3'd0) begin
              state_next     = DAY;
              digit_cnt_next = 3'd0;
            end else fmt_err = 1'b1;
          end
          DAY: begin
            if (is_digit) begin
              if (digit_cnt == 3'd2) fmt_err = 1'b1;
              else begin
                day_sh_next    = {day_sh[3:0], data[3:0]};
                digit_cnt_next = digit_cnt + 3'd1;
              end
            end else if (data == CH_COMMA && digit_cnt == 3'd2) begin
              state_next     = MONTH;
              digit_cnt_next = 3'd0;
            end else fmt_err = 1'b1;
          end
          MONTH: begin
            if (is_digit) begin
              if (digit_cnt == 3'd2) fmt_err = 1'b1;
              else begin
                month_sh_next  = {month_sh[3:0], data[3:0]};
                digit_cnt_next = digit_cnt + 3'd1;
              end
            end else if (data == CH_COMMA && digit_cnt == 3'd2) begin
              state_next     = YEAR;
              digit_cnt_next = 3'd0;
            end else fmt_err = 1'b1;
          end
          YEAR: begin
            if (is_digit) begin
              if (digit_cnt == 3'd4) fmt_err = 1'b1;
              else begin
                year_sh_next   = {year_sh[11:0], data[3:0]};
                digit_cnt_next = digit_cnt + 3'd1;
              end
            end else if (data == CH_COMMA && digit_cnt == 3'd4) begin
              state_next    = SKIP;
              skip_cnt_next = '0;
            end else fmt_err = 1'b1;
          end
          SKIP: begin
            // Local-zone fields are passed over; a runaway tail is rejected
            if (data == CH_STAR) state_next = CK_HI;
            else if (skip_cnt == SKIP_LIMIT) fmt_err = 1'b1;
            else skip_cnt_next = skip_cnt + 1'b1;
          end
          CK_HI: begin
            if (is_hex) begin
              ck_hi_next = hex_val;
              state_next = CK_LO;
            end else fmt_err = 1'b1;
          end
          CK_LO: begin
            if (is_hex) begin
              state_next = IDLE;
              if ({ck_hi, hex_val} == csum) valid_next = 1'b1;
              else begin
                error_next = 1'b1;
                code_next  = 2'd1;
              end
            end else fmt_err = 1'b1;
          end
          default: begin
          end
        endcase

        if (fmt_err) begin
          state_next = IDLE;
          error_next = 1'b1;
          code_next  = 2'd0;
        end
      end
    end
  end

  // State and output registers. The published fields copy the shadows only on
  // an accepted sentence, so a rejected sentence leaves the last good time.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      digit_cnt <= 3'd0;
      skip_cnt  <= '0;
      csum      <= 8'h00;
      ck_hi     <= 4'h0;
      time_sh   <= 24'h0;
      day_sh    <= 8'h0;
      month_sh  <= 8'h0;
      year_sh   <= 16'h0;
      hour      <= 8'h0;
      minute    <= 8'h0;
      second    <= 8'h0;
      day       <= 8'h0;
      month     <= 8'h0;
      year      <= 16'h0;
      valid     <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      state     <= state_next;
      digit_cnt <= digit_cnt_next;
      skip_cnt  <= skip_cnt_next;
      csum      <= csum_next;
      ck_hi     <= ck_hi_next;
      time_sh   <= time_sh_next;
      day_sh    <= day_sh_next;
      month_sh  <= month_sh_next;
      year_sh   <= year_sh_next;
      valid     <= valid_next;
      error     <= error_next;
      err_code  <= code_next;
      if (valid_next) begin
        hour   <= time_sh[23:16];
        minute <= time_sh[15:8];
        second <= time_sh[7:0];
        day    <= day_sh;
        month  <= month_sh;
        year   <= year_sh;
      end
    end
  end

endmodule

// File: tb/tb_gpzda_field_parser.sv
// tb_gpzda_field_parser
//
// Builds byte streams of whole sentences, predicts every valid/error pulse
// with a string-level sentence parser, then plays the stream into the DUT with
// optional idle gaps and compares the pulses and fields after every cycle.

module tb_gpzda_field_parser;

  localparam int MAX_SKIP = 16;

  typedef logic [7:0] ch_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [7:0]  data;
  logic        header_resolve;
  logic [7:0]  hour, minute, second, day, month;
  logic [15:0] year;
  logic        valid, error;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  // Stream under test and the predicted outcome after each byte
  ch_t        s_data[$];
  bit         s_res[$];
  int         e_kind[$];
  logic [1:0] e_code[$];
  logic [55:0] e_fld[$];
  logic [55:0] last_fields = '0;

  gpzda_field_parser #(.MAX_SKIP(MAX_SKIP)) dut (
    .clock(clock), .reset(reset), .load(load), .data(data),
    .header_resolve(header_resolve),
    .hour(hour), .minute(minute), .second(second), .day(day), .month(month),
    .year(year), .valid(valid), .error(error), .err_code(err_code)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle, then sample just after the edge
  task automatic applyStimulus(input logic ld, input logic [7:0] d, input logic res);
    load = ld;
    data = d;
    header_resolve = res;
    @(posedge clock);
    #1;
  endtask

  // ---------------- reference sentence model ----------------
  function automatic bit isDig(input ch_t c);
    return c >= "0" && c <= "9";
  endfunction

  function automatic bit isUHex(input ch_t c);
    return isDig(c) || (c >= "A" && c <= "F");
  endfunction

  function automatic int hexVal(input ch_t c);
    return isDig(c) ? int'(c) - 48 : int'(c) - 55;
  endfunction

  function automatic logic [7:0] xorStr(input string s);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < s.len(); i++) x ^= s[i];
    return x;
  endfunction

  function automatic int digRun(input ch_t b[$], input int p);
    int r = 0;
    while (p + r < b.size() && isDig(b[p + r])) r++;
    return r;
  endfunction

  function automatic void needChar(input ch_t b[$], input ch_t c, inout int p, inout bit done, inout int ev);
    if (done) return;
    if (p >= b.size()) done = 1;
    else if (b[p] != c) begin ev = p; done = 1; end
    else p++;
  endfunction

  function automatic void needDigits(input ch_t b[$], input int cnt, inout int p, inout bit done,
                                     inout int ev, inout logic [55:0] acc);
    int r;
    if (done) return;
    r = digRun(b, p);
    if (r > cnt) begin ev = p + cnt; done = 1; end
    else if (p + r >= b.size()) done = 1;
    else if (r < cnt) begin ev = p + r; done = 1; end
    else begin
      for (int k = 0; k < cnt; k++) acc = {acc[51:0], b[p + k][3:0]};
      p += cnt;
    end
  endfunction

  // Body = bytes after the resolving 'A' up to the next resolve.
  // ev: index of the byte that ends the sentence (-1 if none); kind 1 valid, 2 error
  function automatic void parseBody(input ch_t b[$], output int ev, output int kind,
                                    output logic [1:0] code, output logic [55:0] f);
    int n, p, r, star, d;
    bit done;
    logic [55:0] acc;
    logic [7:0] ck;
    string pre;
    n = b.size(); p = 0; done = 0; acc = '0; star = -1; d = -1;
    ev = -1; kind = 0; code = 2'd0; f = '0;
    needChar(b, ",", p, done, ev);
    needDigits(b, 6, p, done, ev, acc);
    if (!done) begin
      if (p >= n) done = 1;
      else if (b[p] == ",") p++;
      else if (b[p] == ".") begin
        p++;
        r = digRun(b, p);
        if (p >= n) done = 1;
        else if (r == 0) begin ev = p; done = 1; end
        else if (r > 3) begin ev = p + 3; done = 1; end
        else if (p + r >= n) done = 1;
        else p += r;
        needChar(b, ",", p, done, ev);
      end else begin ev = p; done = 1; end
    end
    needDigits(b, 2, p, done, ev, acc);
    needChar(b, ",", p, done, ev);
    needDigits(b, 2, p, done, ev, acc);
    needChar(b, ",", p, done, ev);
    needDigits(b, 4, p, done, ev, acc);
    needChar(b, ",", p, done, ev);
    if (!done) begin
      for (int i = 0; i <= MAX_SKIP; i++) begin
        if (p + i >= n) begin done = 1; break; end
        if (b[p + i] == "*") begin star = p + i; break; end
        if (i == MAX_SKIP) begin ev = p + i; done = 1; break; end
      end
    end
    if (!done) begin
      if (star + 1 >= n) done = 1;
      else if (!isUHex(b[star + 1])) ev = star + 1;
      else if (star + 2 >= n) done = 1;
      else if (!isUHex(b[star + 2])) ev = star + 2;
      else begin
        pre = "GPZDA";
        for (int i = 0; i < star; i++) pre = $sformatf("%s%c", pre, b[i]);
        ck = xorStr(pre);
        ev = star + 2;
        if (hexVal(b[star + 1]) * 16 + hexVal(b[star + 2]) == int'(ck)) begin
          kind = 1; f = acc;
        end else begin
          kind = 2; code = 2'd1;
        end
      end
    end
    if (ev >= 0 && kind == 0) kind = 2;
    for (int i = 0; i < n; i++) if (b[i] == "$") begin d = i; break; end
    if (d >= 0 && (ev < 0 || d <= ev)) begin
      ev = d; kind = 2; code = 2'd2; f = '0;
    end
  endfunction

  // ---------------- stream construction ----------------
  function automatic string hex2(input logic [7:0] v, input bit lower);
    string s = "";
    logic [3:0] nib;
    for (int i = 1; i >= 0; i--) begin
      nib = v[i*4 +: 4];
      if (nib < 10) s = $sformatf("%s%c", s, 8'h30 + nib);
      else s = $sformatf("%s%c", s, (lower ? 8'h61 : 8'h41) + nib - 10);
    end
    return s;
  endfunction

  function automatic string withCk(input string b);
    return $sformatf("%s*%s", b, hex2(xorStr({"GPZDA", b}), 1'b0));
  endfunction

  task automatic pushStr(input string s, input bit resLast);
    for (int i = 0; i < s.len(); i++) begin
      s_data.push_back(s[i]);
      s_res.push_back(resLast && (i == s.len() - 1));
    end
  endtask

  task automatic pushSentence(input string hdr, input string body);
    pushStr(hdr, 1'b1);
    pushStr(body, 1'b0);
  endtask

  task automatic computeExpect();
    int n, j, ev, kind;
    logic [1:0] code;
    logic [55:0] f;
    ch_t body[$];
    n = s_data.size();
    e_kind = {}; e_code = {}; e_fld = {};
    for (int i = 0; i < n; i++) begin
      e_kind.push_back(0); e_code.push_back(2'd0); e_fld.push_back('0);
    end
    for (int i = 0; i < n; i++) begin
      if (s_res[i]) begin
        body = {};
        j = i + 1;
        while (j < n && !s_res[j]) begin body.push_back(s_data[j]); j++; end
        parseBody(body, ev, kind, code, f);
        if (ev >= 0) begin
          e_kind[i + 1 + ev] = kind;
          e_code[i + 1 + ev] = code;
          e_fld[i + 1 + ev]  = f;
        end
      end
    end
  endtask

  task automatic runStream(input int maxGap);
    int gaps;
    computeExpect();
    for (int i = 0; i < s_data.size(); i++) begin
      gaps = $urandom_range(maxGap, 0);
      for (int g = 0; g < gaps; g++) begin
        applyStimulus(1'b0, 8'($urandom), 1'b0);
        checkOutput($sformatf("gap_pulse@%0d", i), {62'd0, valid, error}, 64'd0);
      end
      applyStimulus(1'b1, s_data[i], s_res[i]);
      case (e_kind[i])
        1: begin
          last_fields = e_fld[i];
          checkOutput($sformatf("valid_pulse@%0d", i), {62'd0, valid, error}, 64'd2);
          checkOutput($sformatf("fields@%0d", i), {8'd0, hour, minute, second, day, month, year},
                      {8'd0, last_fields});
        end
        2: begin
          checkOutput($sformatf("error_pulse@%0d", i), {62'd0, valid, error}, 64'd1);
          checkOutput($sformatf("err_code@%0d", i), {62'd0, err_code}, {62'd0, e_code[i]});
          checkOutput($sformatf("kept_fields@%0d", i), {8'd0, hour, minute, second, day, month, year},
                      {8'd0, last_fields});
        end
        default:
          checkOutput($sformatf("no_pulse@%0d", i), {62'd0, valid, error}, 64'd0);
      endcase
    end
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("trailing_pulse", {62'd0, valid, error}, 64'd0);
    s_data = {}; s_res = {};
  endtask

  task automatic addRandomSentence();
    string body, fr, sk, hdr;
    int sel, len, pos;
    logic [7:0] ck, c;
    body = $sformatf(",%02d%02d%02d", $urandom_range(99, 0), $urandom_range(99, 0), $urandom_range(99, 0));
    sel = $urandom_range(9, 0);
    if (sel == 0) fr = ".";
    else if (sel == 1) fr = ".1234";
    else if (sel < 4) fr = "";
    else begin
      fr = ".";
      for (int k = 0; k < $urandom_range(3, 1); k++) fr = $sformatf("%s%0d", fr, $urandom_range(9, 0));
    end
    body = {body, fr, $sformatf(",%02d,%02d,%04d,", $urandom_range(99, 0), $urandom_range(99, 0),
                                 $urandom_range(9999, 0))};
    sk = "";
    len = $urandom_range(MAX_SKIP + 2, 0);
    for (int k = 0; k < len; k++) begin
      c = 8'($urandom_range(126, 32));
      if (c == "$" || c == "*") c = "0";
      sk = $sformatf("%s%c", sk, c);
    end
    body = {body, sk};
    ck = xorStr({"GPZDA", body});
    sel = $urandom_range(9, 0);
    if (sel == 0) ck ^= 8'(1 << $urandom_range(7, 0));
    body = {body, "*", hex2(ck, sel == 1)};
    if ($urandom_range(5, 0) == 0) begin
      pos = $urandom_range(body.len() - 1, 0);
      body = $sformatf("%s%c%s", body.substr(0, pos - 1), 8'($urandom_range(126, 32)),
                       body.substr(pos + 1, body.len() - 1));
    end
    if ($urandom_range(9, 0) == 0) body = body.substr(0, $urandom_range(body.len() - 1, 0));
    if ($urandom_range(1, 0) == 0) body = {body, "\015\012"};
    hdr = ($urandom_range(7, 0) == 0) ? "A" : "$GPZDA";
    pushSentence(hdr, body);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    string s1, s1bad, s2;
    s1    = ",201530.00,04,07,2002,00,00*60";
    s1bad = ",201530.00,04,07,2002,00,00*61";
    s2    = withCk(",235959,31,12,1999,");

    reset = 1'b1; load = 1'b0; data = 8'h00; header_resolve = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("reset_pulse", {62'd0, valid, error}, 64'd0);
    checkOutput("reset_code", {62'd0, err_code}, 64'd0);
    checkOutput("reset_fields", {8'd0, hour, minute, second, day, month, year}, 64'd0);

    $display("[TB] directed sentences, back-to-back bytes");
    pushSentence("$GPZDA", s1);
    pushSentence("$GPZDA", s1bad);
    pushSentence("$GPZDA", ",2015X0.00,04,07,2002,00,00*60");
    pushSentence("$GPZDA", s1);
    pushSentence("$GPZDA", ",201530.00,04,");
    pushSentence("$GPZDA", s1);
    pushSentence("$GPZDA", ",201530.00,04,07,20");
    pushSentence("A", s2);
    pushSentence("$GPZDA", withCk(",120000.123,01,02,2024,0123456789ABCDEF"));
    pushSentence("$GPZDA", withCk(",120000.123,01,02,2024,0123456789ABCDEFG"));
    pushSentence("$GPZDA", withCk(",120000.1234,01,02,2024,"));
    pushSentence("$GPZDA", withCk(",120000.,01,02,2024,"));
    pushSentence("$GPZDA", ",201530.00,04,07,2002,00,00*6a");
    pushSentence("$GPZDA", s2);
    runStream(0);

    $display("[TB] reset in the middle of the year field");
    pushSentence("$GPZDA", ",201530.00,04,07,20");
    runStream(0);
    reset = 1'b1;
    applyStimulus(1'b1, "0", 1'b0);
    checkOutput("midreset_pulse0", {62'd0, valid, error}, 64'd0);
    applyStimulus(1'b1, "2", 1'b0);
    checkOutput("midreset_pulse1", {62'd0, valid, error}, 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midreset_fields", {8'd0, hour, minute, second, day, month, year}, 64'd0);
    last_fields = '0;
    pushSentence("$GPZDA", s1);
    runStream(0);

    $display("[TB] idle gaps with garbage data");
    pushSentence("$GPZDA", {s1, "\015\012"});
    pushSentence("$GPZDA", s1bad);
    pushSentence("$GPZDA", s2);
    pushSentence("$GPZDA", s1);
    runStream(5);

    $display("[TB] randomized sentences");
    for (int k = 0; k < 60; k++) addRandomSentence();
    pushSentence("$GPZDA", s1);
    runStream(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpzda_field_parser.md
# gpzda_field_parser

Downstream stage of the `$GPZDA` header comparer in the NMEA receive path. The header comparer signals that the six-byte header `$GPZDA` has just been loaded. From that point this block consumes the same UART byte stream, parses the time and date fields of the sentence, and checks the NMEA XOR checksum. It then publishes the decoded BCD time/date with a one-cycle valid pulse, or flags an error.

## Interface
- `MAX_SKIP`, 16, max bytes accepted between the end of the year field and `*`.
- `clock`  in  1  system clock, 100 MHz.
- `reset`  in  1  synchronous, active-high; one clock with reset=1 fully reinitialises the block.
- `load`  in  1  `data` is a new received byte this cycle. Same strobe that feeds the header comparer.
- `data`  in  8  received ASCII byte.
- `header_resolve`  in  1  comparer `resolve`; high in the same cycle that the final `A` is loaded.
- `hour`, `minute`, `second`, `day`, `month`  out  8 each  BCD, two digits.
- `year`  out  16  BCD, four digits.
- `valid`  out  1  one-cycle pulse; outputs updated this cycle.
- `error`  out  1  one-cycle pulse; sentence rejected.
- `err_code`  out  2  0 format, 1 checksum, 2 aborted by `$`. Meaningful only with `error`.

## Operation
- States:
  - IDLE
  - COMMA0
  - TIME
  - FRAC
  - DAY
  - MONTH
  - YEAR
  - SKIP
  - CK_HI
  - CK_LO
- A 3-bit digit counter tracks position within the current field.
- IDLE: when `header_resolve` is high, go to COMMA0 and set the running checksum to 0x48. 0x48 is the XOR of `GPZDA`. All other bytes are ignored in IDLE.
- Checksum scope: every loaded byte after the header up to, but excluding, `*` is XORed into the running checksum.
- COMMA0: expects `,` and then goes to TIME.
- TIME: accepts exactly 6 digits (hhmmss) into shadow registers, then:
  - `.` goes to FRAC;
  - `,` goes to DAY.
- FRAC: accepts 1–3 digits, which are discarded, then `,`. Zero digits or a fourth digit is a format error.
- DAY, MONTH: each accepts exactly 2 digits, then `,`.
- YEAR: accepts exactly 4 digits, then `,`.
- SKIP: accepts any bytes except `$`, then `*` goes to CK_HI. More than `MAX_SKIP` bytes is a format error.
- CK_HI, CK_LO: each accepts one uppercase hex digit (`0`–`9`, `A`–`F`).
  - On CK_LO, compare the received value with the running checksum: equal gives `valid`, unequal gives `error` with code 1.
  - Either way, return to IDLE.
- Format errors (code 0):
  - any non-digit where a digit is expected;
  - wrong digit count in a field;
  - any byte other than the expected delimiter;
  - lowercase hex.
  - The block pulses `error` and returns to IDLE.
- A `$` loaded in any non-IDLE state gives error code 2 and returns to IDLE.
- `header_resolve` in any non-IDLE state restarts at COMMA0 with the checksum reset to 0x48, and no error is pulsed. This takes priority over the byte's normal handling.
- Values are range-agnostic: digits are checked as 0–9 only, with no calendar validation.
- Output registers load from the shadows only on `valid`. On `error` they keep their last valid values.

## Timing
- Reset values:
  - all outputs 0, including `valid`, `error` and `err_code`;
  - state IDLE, checksum 0, shadows 0.
- Only cycles with `load`=1 advance the state machine. With `load`=0 all state holds, regardless of `data`.
- `valid`/`error` are registered. They go high in the cycle after the clock edge that loads the terminating byte (second checksum char, or offending byte), and last exactly 1 cycle.
- Updated data outputs become visible in the same cycle as `valid`.
- Back-to-back bytes (`load` every cycle) are fully supported. The first byte following the header may arrive on the very next cycle.
- `reset` in mid-sentence: no `valid`/`error` pulse; the block returns to IDLE.
- Trailing CR/LF after the checksum are ignored in IDLE.

## Test plan
- Full sentence `$GPZDA,201530.00,04,07,2002,00,00*60` loaded at 1 byte/cycle with `header_resolve` on `A`:
  - required: `valid` 1 cycle after `0` is loaded;
  - hour=0x20, minute=0x15, second=0x30, day=0x04, month=0x07, year=0x2002, no `error`.
- Same sentence with checksum `*61`: `error`, `err_code`=1, outputs unchanged from the previous value.
- Same sentence with `load` gaps of 0–5 random idle cycles and garbage on `data` during the gaps: identical result to the first case.
- `$GPZDA,2015X0.00,...`: `error` with code 0 one cycle after `X`. A following valid sentence then parses correctly.
- `$` injected after the day field: `error` code 2. The next full sentence parses and gives `valid`.
- `reset` asserted mid-year field, then a full sentence: no pulse during the reset; the sentence is `valid`. Separately, `header_resolve` during YEAR restarts the parse silently.
